// File: rtl/taylor_coeff_fetch.sv
// Read-side sequencer for the registered-output coefficient ROM: fetches one segment's
// Taylor coefficients highest order first and streams them over a valid/ready channel.
module taylor_coeff_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 5,
    parameter int COEFF_BITS = 2,
    localparam int SEG_BITS  = ADDR_LINES - COEFF_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [SEG_BITS-1:0]   req_seg_i,
    output logic [ADDR_LINES-1:0] rom_addr_o,
    output logic                  rom_rd_en_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic                  coef_valid_o,
    input  logic                  coef_ready_i,
    output logic [DATA_WIDTH-1:0] coef_data_o,
    output logic [COEFF_BITS-1:0] coef_idx_o,
    output logic                  coef_last_o,
    output logic                  busy_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [COEFF_BITS-1:0] K_TOP = '1;

    logic [1:0]            state;
    logic [SEG_BITS-1:0]   seg;
    logic [COEFF_BITS-1:0] k;
    logic                  inflight;
    logic [COEFF_BITS-1:0] inflight_k;
    logic [ADDR_LINES-1:0] last_addr;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [COEFF_BITS-1:0] fifo_idx  [2];
    logic [1:0]            fifo_count;
    logic                  rd_ptr;
    logic                  wr_ptr;

    logic                  pop;
    logic                  issue;
    logic [2:0]            occupancy;
    logic [COEFF_BITS-1:0] head_idx;

    assign head_idx     = fifo_idx[rd_ptr];
    assign coef_valid_o = (fifo_count != 2'd0);
    assign pop          = coef_valid_o && coef_ready_i;

    // Buffered plus in-flight words after this cycle's pop must leave room for one more read.
    assign occupancy    = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue        = (state == FETCH) && (occupancy < 3'd2);

    assign rom_rd_en_o  = issue;
    assign rom_addr_o   = issue ? {seg, k} : last_addr;

    assign req_ready_o  = (state == IDLE);
    assign busy_o       = (state != IDLE);

    assign coef_data_o  = coef_valid_o ? fifo_data[rd_ptr] : '0;
    assign coef_idx_o   = coef_valid_o ? head_idx : '0;
    assign coef_last_o  = coef_valid_o && (head_idx == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            seg        <= '0;
            k          <= '0;
            inflight   <= 1'b0;
            inflight_k <= '0;
            last_addr  <= '0;
            fifo_count <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        seg   <= req_seg_i;
                        k     <= K_TOP;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        k <= k - 1'b1;
                        if (k == '0) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && coef_last_o) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            inflight <= issue;
            if (issue) begin
                inflight_k <= k;
                last_addr  <= {seg, k};
            end

            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({inflight, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked solely by fifo_count.
    always_ff @(posedge clk_i) begin
        if (!rst_i && inflight) begin
            fifo_data[wr_ptr] <= rom_data_i;
            fifo_idx[wr_ptr]  <= inflight_k;
        end
    end

endmodule

// File: tb/tb_taylor_coeff_fetch.sv
// Randomized self-checking bench for taylor_coeff_fetch with a transaction-level
// reference model (expected read addresses and beats per accepted segment).
module tb_taylor_coeff_fetch;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_seg;
    logic [4:0]  rom_addr;
    logic        rom_rd_en;
    logic [31:0] rom_data;
    logic        coef_valid;
    logic        coef_ready;
    logic [31:0] coef_data;
    logic [1:0]  coef_idx;
    logic        coef_last;
    logic        busy;

    taylor_coeff_fetch #(
        .DATA_WIDTH(32),
        .ADDR_LINES(5),
        .COEFF_BITS(2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_seg_i   (req_seg),
        .rom_addr_o  (rom_addr),
        .rom_rd_en_o (rom_rd_en),
        .rom_data_i  (rom_data),
        .coef_valid_o(coef_valid),
        .coef_ready_i(coef_ready),
        .coef_data_o (coef_data),
        .coef_idx_o  (coef_idx),
        .coef_last_o (coef_last),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] rom_img [32];
    initial rom_data = 32'd0;
    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom_img[rom_addr];
    end

    // 0: ready high, 1: ready low, 2: toggle, 3: random
    int ready_mode = 0;
    initial coef_ready = 1'b1;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       coef_ready = 1'b1;
            1:       coef_ready = 1'b0;
            2:       coef_ready = ~coef_ready;
            default: coef_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic failNote(input string name, input int act, input int exp);
        total++;
        bad++;
        $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model state
    bit          active = 0;
    int          outstanding = 0;
    int          exp_addr [$];
    logic [31:0] exp_data [$];
    int          exp_k    [$];

    // Per-test observation logs
    int cyc = 0;
    int rd_total = 0;
    int accept_cyc = -1;
    int first_valid_cyc = -1;
    int log_addr [$];
    int log_rd_cyc [$];
    int log_data [$];
    int log_idx [$];
    int log_last [$];
    int log_hs_cyc [$];

    bit          stall_prev = 0;
    logic [31:0] prev_data;
    logic [1:0]  prev_idx;
    logic        prev_last;

    // Single compare process: every cycle, check outputs against the model, then advance it.
    always @(negedge clk) begin
        bit act0;
        cyc++;
        if (rst) begin
            active = 0;
            outstanding = 0;
            exp_addr.delete();
            exp_data.delete();
            exp_k.delete();
            stall_prev = 0;
        end else begin
            act0 = active;
            checkOutput("req_ready", 32'(req_ready), 32'(!act0));
            checkOutput("busy", 32'(busy), 32'(act0));
            if (stall_prev) begin
                checkOutput("stall_valid", 32'(coef_valid), 32'd1);
                checkOutput("stall_data", coef_data, prev_data);
                checkOutput("stall_idx", 32'(coef_idx), 32'(prev_idx));
                checkOutput("stall_last", 32'(coef_last), 32'(prev_last));
            end
            if (coef_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rom_rd_en) begin
                rd_total++;
                log_addr.push_back(int'(rom_addr));
                log_rd_cyc.push_back(cyc);
                outstanding++;
                if (exp_addr.size() == 0) failNote("unexpected_read", int'(rom_addr), -1);
                else checkOutput("rd_addr", 32'(rom_addr), 32'(exp_addr.pop_front()));
            end
            if (coef_valid && coef_ready) begin
                log_data.push_back(int'(coef_data));
                log_idx.push_back(int'(coef_idx));
                log_last.push_back(int'(coef_last));
                log_hs_cyc.push_back(cyc);
                outstanding--;
                if (exp_data.size() == 0) begin
                    failNote("extra_beat", int'(coef_data), -1);
                end else begin
                    int ek;
                    ek = exp_k.pop_front();
                    checkOutput("beat_data", coef_data, exp_data.pop_front());
                    checkOutput("beat_idx", 32'(coef_idx), 32'(ek));
                    checkOutput("beat_last", 32'(coef_last), 32'(ek == 0));
                    if (ek == 0) active = 0;
                end
            end
            checkOutput("occupancy_le_2", 32'(outstanding <= 2), 32'd1);
            if (req_valid && !act0) begin
                active = 1;
                accept_cyc = cyc;
                for (int kk = 3; kk >= 0; kk--) begin
                    int a;
                    a = int'(req_seg) * 4 + kk;
                    exp_addr.push_back(a);
                    exp_data.push_back(rom_img[a]);
                    exp_k.push_back(kk);
                end
            end
            stall_prev = coef_valid && !coef_ready;
            prev_data  = coef_data;
            prev_idx   = coef_idx;
            prev_last  = coef_last;
        end
    end

    task automatic clearLogs();
        log_addr.delete();
        log_rd_cyc.delete();
        log_data.delete();
        log_idx.delete();
        log_last.delete();
        log_hs_cyc.delete();
        accept_cyc = -1;
        first_valid_cyc = -1;
    endtask

    task automatic applyStimulus(input int seg);
        bit seen;
        seen = 0;
        @(posedge clk) #1;
        req_valid = 1'b1;
        req_seg   = 3'(seg);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready) begin
                seen = 1;
                break;
            end
        end
        if (!seen) failNote("req_accept_timeout", 0, 1);
        @(posedge clk) #1;
        req_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        bit done;
        done = 0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk) #1;
            if (!active && exp_data.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) failNote("idle_timeout", exp_data.size(), 0);
    endtask

    task automatic checkSeq(input string name, input int got[$], input int exp[8], input int n);
        checkOutput({name, "_len"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) checkOutput(name, 32'(got[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got 1 expected 0");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rd0;
        bit seen;
        for (int i = 0; i < 32; i++) rom_img[i] = 32'(i);
        rst = 1'b1;
        req_valid = 1'b0;
        req_seg = 3'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(coef_valid), 32'd0);
        checkOutput("rst_rd_en", 32'(rom_rd_en), 32'd0);
        checkOutput("rst_addr", 32'(rom_addr), 32'd0);
        checkOutput("rst_data", coef_data, 32'd0);
        checkOutput("rst_last", 32'(coef_last), 32'd0);

        $display("[TB] test 1: seg 2, ready high");
        clearLogs();
        ready_mode = 0;
        applyStimulus(2);
        waitIdle(100);
        checkSeq("t1_addr", log_addr, '{11, 10, 9, 8, 0, 0, 0, 0}, 4);
        checkSeq("t1_idx", log_idx, '{3, 2, 1, 0, 0, 0, 0, 0}, 4);
        checkSeq("t1_last", log_last, '{0, 0, 0, 1, 0, 0, 0, 0}, 4);
        if (log_rd_cyc.size() == 4) checkOutput("t1_read_span", 32'(log_rd_cyc[3] - log_rd_cyc[0]), 32'd3);
        if (log_hs_cyc.size() == 4) checkOutput("t1_beat_span", 32'(log_hs_cyc[3] - log_hs_cyc[0]), 32'd3);
        checkOutput("t1_latency", 32'(first_valid_cyc - accept_cyc), 32'd3);
        @(negedge clk);
        checkOutput("t1_ready_after", 32'(req_ready), 32'd1);

        $display("[TB] test 2: seg 5 with 10-cycle stall");
        clearLogs();
        ready_mode = 1;
        applyStimulus(5);
        rd0 = rd_total;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t2_reads_in_stall", 32'(rd_total - rd0), 32'd2);
        checkOutput("t2_rd_en_low", 32'(rom_rd_en), 32'd0);
        checkOutput("t2_head_data", coef_data, 32'd23);
        ready_mode = 0;
        waitIdle(100);
        checkSeq("t2_addr", log_addr, '{23, 22, 21, 20, 0, 0, 0, 0}, 4);
        checkSeq("t2_data", log_data, '{23, 22, 21, 20, 0, 0, 0, 0}, 4);

        $display("[TB] test 3: seg 1, toggling ready");
        clearLogs();
        ready_mode = 2;
        applyStimulus(1);
        waitIdle(100);
        checkSeq("t3_data", log_data, '{7, 6, 5, 4, 0, 0, 0, 0}, 4);
        ready_mode = 0;

        $display("[TB] test 4: back-to-back requests seg 0 then 7");
        clearLogs();
        @(posedge clk) #1;
        req_valid = 1'b1;
        req_seg = 3'd0;
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready) begin seen = 1; break; end
        end
        if (!seen) failNote("t4_first_accept", 0, 1);
        @(posedge clk) #1;
        req_seg = 3'd7;
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready) begin seen = 1; break; end
        end
        if (!seen) failNote("t4_second_accept", 0, 1);
        @(posedge clk) #1;
        req_valid = 1'b0;
        waitIdle(100);
        checkSeq("t4_data", log_data, '{3, 2, 1, 0, 31, 30, 29, 28}, 8);

        $display("[TB] test 5: reset mid-segment");
        clearLogs();
        ready_mode = 0;
        applyStimulus(3);
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            if (log_data.size() >= 2) begin seen = 1; break; end
            @(posedge clk) #1;
        end
        if (!seen) failNote("t5_two_beats", log_data.size(), 2);
        rst = 1'b1;
        ready_mode = 1;
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_valid", 32'(coef_valid), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_req_ready", 32'(req_ready), 32'd1);
        clearLogs();
        ready_mode = 0;
        applyStimulus(4);
        waitIdle(100);
        checkSeq("t5_data", log_data, '{19, 18, 17, 16, 0, 0, 0, 0}, 4);

        $display("[TB] test 6: random image sweep, random ready");
        for (int i = 0; i < 32; i++) rom_img[i] = $urandom;
        clearLogs();
        ready_mode = 3;
        for (int s = 0; s < 8; s++) applyStimulus(s);
        waitIdle(400);
        checkOutput("t6_beats", 32'(log_data.size()), 32'd32);
        ready_mode = 0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
